// File: rtl/nr4sdp_serial_mult.sv
// Iterative 16x16 signed multiplier consuming NR4SD+ digits (7) plus one MB top digit.
// Optional zero-digit early exit: define NR4SDP_SERIAL_MULT_ZERO_SKIP_EN.
module nr4sdp_serial_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  nm,
    input  logic [6:0]  np,
    input  logic        sign,
    input  logic        one,
    input  logic        two,
    input  logic [15:0] b,
    output logic        ready,
    output logic        done,
    output logic [31:0] p
);

    // state | meaning
    // IDLE  | ready=1, waiting for start; operands latched on accept
    // RUN   | one radix-4 partial product per cycle, digit index k
    // DONE  | p/done loaded on entry; returns to IDLE next cycle
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [6:0]   nm_r, np_r;
    logic         sign_r, one_r, two_r;
    logic [15:0]  b_r;
    logic [31:0]  acc;
    logic [2:0]   k;

    logic               neg, mag1, mag2, last;
    logic signed [17:0] b_ext, mag, pp;
    logic signed [31:0] pp_ext, pp_sh;
    logic [31:0]        acc_nxt;

    assign b_ext = {{2{b_r[15]}}, b_r};

    // Digit decode: (np,nm) 00->0, 01->-1, 11->+1, 10->+2. one&two is treated as magnitude 1.
    always_comb begin
        neg  = 1'b0;
        mag1 = 1'b0;
        mag2 = 1'b0;
        if (k == 3'd7) begin
            neg  = sign_r;
            mag1 = one_r;
            mag2 = two_r & ~one_r;
        end else begin
            neg  = nm_r[k] & ~np_r[k];
            mag1 = nm_r[k];
            mag2 = np_r[k] & ~nm_r[k];
        end
    end

    always_comb begin
        mag = 18'sd0;
        if (mag1)
            mag = b_ext;
        else if (mag2)
            mag = b_ext <<< 1;
        pp = neg ? -mag : mag;
    end

    assign pp_ext  = {{14{pp[17]}}, pp};
    assign pp_sh   = pp_ext <<< {k, 1'b0};
    assign acc_nxt = acc + $unsigned(pp_sh);

`ifdef NR4SDP_SERIAL_MULT_ZERO_SKIP_EN
    logic [7:0] nz, upper;
    assign nz    = {one_r | two_r, nm_r | np_r};
    assign upper = nz >> k;
    assign last  = (k == 3'd7) || (upper[7:1] == 7'd0);
`else
    assign last  = (k == 3'd7);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            p      <= 32'd0;
            acc    <= 32'd0;
            k      <= 3'd0;
            nm_r   <= 7'd0;
            np_r   <= 7'd0;
            sign_r <= 1'b0;
            one_r  <= 1'b0;
            two_r  <= 1'b0;
            b_r    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        nm_r   <= nm;
                        np_r   <= np;
                        sign_r <= sign;
                        one_r  <= one;
                        two_r  <= two;
                        b_r    <= b;
                        acc    <= 32'd0;
                        k      <= 3'd0;
                        ready  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (last) begin
                        p     <= acc_nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nr4sdp_serial_mult.sv
// Bench for nr4sdp_serial_mult: behavioural NR4SD+ encoder upstream, latency/product model,
// per-cycle compare plus directed literal checks. Honours NR4SDP_SERIAL_MULT_ZERO_SKIP_EN.
module tb_nr4sdp_serial_mult;

    logic               clk = 1'b0;
    logic               rst, start;
    logic signed [15:0] a_drv, b_drv;
    logic [6:0]         nm, np;
    logic               sign, one, two;
    logic               ready, done;
    logic [31:0]        p;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Greedy NR4SD+ recoding: low digits in {-1,0,1,2}, remaining top value is the MB digit.
    function automatic logic [16:0] enc(input logic signed [15:0] a);
        int x, r, d;
        logic [6:0] vm, vp;
        logic s, o, t;
        x = int'(a);
        vm = '0;
        vp = '0;
        for (int j = 0; j < 7; j++) begin
            r = x & 3;
            d = (r == 3) ? -1 : r;
            vm[j] = (d == -1) || (d == 1);
            vp[j] = (d == 1) || (d == 2);
            x = (x - d) >>> 2;
        end
        s = (x < 0);
        o = (x == 1) || (x == -1);
        t = (x == 2) || (x == -2);
        return {s, o, t, vp, vm};
    endfunction

    function automatic int k_last(input logic signed [15:0] a);
        logic [16:0] e;
        int kl;
        e = enc(a);
        kl = 0;
        for (int j = 0; j < 7; j++)
            if (e[j] || e[7+j]) kl = j;
        if (e[15] || e[14]) kl = 7;
        return kl;
    endfunction

    function automatic int model_lat(input logic signed [15:0] a);
`ifdef NR4SDP_SERIAL_MULT_ZERO_SKIP_EN
        return 2 + k_last(a);
`else
        return 9 + 0 * k_last(a);
`endif
    endfunction

    assign {sign, one, two, np, nm} = enc(a_drv);

    nr4sdp_serial_mult dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .nm    (nm),
        .np    (np),
        .sign  (sign),
        .one   (one),
        .two   (two),
        .b     (b_drv),
        .ready (ready),
        .done  (done),
        .p     (p)
    );

    // Model: accepted request finishes L edges later; done visible after edge t+L-1.
    logic        m_valid = 1'b0;
    logic        m_ready, m_done;
    logic [31:0] m_p, m_pend;
    int          m_busy;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 0;
            m_ready = 1'b1;
            m_done  = 1'b0;
            m_p     = 32'd0;
        end else if (m_valid) begin
            if (m_busy == 0) begin
                m_done = 1'b0;
                if (start) begin
                    m_pend  = 32'(int'(a_drv) * int'(b_drv));
                    m_busy  = model_lat(a_drv);
                    m_ready = 1'b0;
                end
            end else begin
                m_busy = m_busy - 1;
                if (m_busy == 1) begin
                    m_done = 1'b1;
                    m_p    = m_pend;
                end else if (m_busy == 0) begin
                    m_done  = 1'b0;
                    m_ready = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if (ready !== m_ready || done !== m_done || p !== m_p) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t: ready=%b done=%b p=%h, required ready=%b done=%b p=%h",
                         $time, ready, done, p, m_ready, m_done, m_p);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) chk("wait_ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    // Issue one request from a negedge, then scramble inputs; measure done latency in edges.
    task automatic run_op(input string name, input logic signed [15:0] a, input logic signed [15:0] bb,
                          input logic [31:0] exp_p, input int exp_lat);
        int e;
        wait_ready();
        a_drv = a;
        b_drv = bb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_drv = 16'($urandom);
        b_drv = 16'($urandom);
        e = 0;
        while (done !== 1'b1 && e < 20) begin
            @(negedge clk);
            e++;
        end
        chk({name, "_p"}, p, exp_p);
        chk({name, "_lat"}, 32'(e + 1), 32'(exp_lat));
    endtask

`ifdef NR4SDP_SERIAL_MULT_ZERO_SKIP_EN
    localparam int LAT_3 = 3, LAT_M1 = 2, LAT_0 = 2, LAT_M5 = 3;
`else
    localparam int LAT_3 = 9, LAT_M1 = 9, LAT_0 = 9, LAT_M5 = 9;
`endif

    initial begin
        int n_done;
        rst   = 1'b1;
        start = 1'b1;
        a_drv = 16'sd3;
        b_drv = 16'sd5;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_p", p, 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        run_op("a3_b5", 16'sd3, 16'sd5, 32'd15, LAT_3);
        run_op("min_min", -16'sd32768, -16'sd32768, 32'h4000_0000, 9);
        run_op("m1_b1234", -16'sd1, 16'sd1234, 32'hFFFF_FB2E, LAT_M1);
        run_op("zero", 16'sd0, 16'sh7FFF, 32'd0, LAT_0);
        run_op("max_min", 16'sd32767, -16'sd32768, 32'hC000_8000, 9);

        // Reset during RUN k=4: accept at edge t, rst sampled at edge t+5.
        wait_ready();
        a_drv = 16'sd100;
        b_drv = 16'sd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_p", p, 32'd0);
        run_op("m5_m9", -16'sd5, -16'sd9, 32'd45, LAT_M5);

        // start held high while encoder inputs change every cycle.
        wait_ready();
        start  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            a_drv = 16'($urandom);
            b_drv = 16'($urandom);
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
`ifndef NR4SDP_SERIAL_MULT_ZERO_SKIP_EN
        chk("held_start_done_count", 32'(n_done), 32'd4);
`endif

        for (int i = 0; i < 20000; i++) begin
            a_drv = 16'($urandom);
            b_drv = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
